pts_unloader: RTL and testbench
===============================

PTS_UNLOADER -- requirements
Module: pts_unloader

Interface
REQ-001 Parameter NUM_SAMPLES, default 48, SHALL set the number of samples per frame.
REQ-002 Parameter SAMPLE_W, default 16, SHALL set the bits per sample.
REQ-003 clk  input  1  SHALL be the single clock (400 MHz); all logic is on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 load_strobe  input  1  SHALL request capture of a frame, active-high, one cycle.
REQ-006 data_par_out  input  [NUM_SAMPLES-1:0][SAMPLE_W-1:0]  SHALL carry the FFT result frame; element 0 is the first sample.
REQ-007 serial_ready  input  1  SHALL indicate that downstream accepts a sample this cycle.
REQ-008 serial_out  output  SAMPLE_W  SHALL be the current sample.
REQ-009 serial_valid  output  1  SHALL mark serial_out as valid.
REQ-010 serial_last  output  1  SHALL mark the final sample of a frame; it is qualified by serial_valid.
REQ-011 busy  output  1  SHALL be high from the cycle after an accepted load until the last sample transfers.
REQ-012 frame_done  output  1  SHALL pulse for one cycle after the last sample transfers.
REQ-013 load_err  output  1  SHALL pulse for one cycle when a load_strobe is rejected.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE, load_strobe=1 SHALL capture all of data_par_out into a frame register, clear the index to 0 and move to SHIFT on the next edge.
REQ-016 In SHIFT, serial_valid SHALL be 1 and serial_out SHALL equal frame[index], registered with no combinational path from data_par_out.
REQ-017 A transfer SHALL occur when serial_valid=1 and serial_ready=1 in the same cycle; index then increments by 1.
REQ-018 serial_out and serial_valid SHALL hold stable while serial_valid=1 and serial_ready=0.
REQ-019 serial_last SHALL be 1 exactly when in SHIFT and index = NUM_SAMPLES-1.
REQ-020 A transfer with index = NUM_SAMPLES-1 SHALL move the FSM to DONE, with no index wrap beyond NUM_SAMPLES-1.
REQ-021 DONE SHALL last one cycle, assert frame_done and return to IDLE; serial_valid and busy SHALL be 0 in DONE.
REQ-022 The first valid sample SHALL appear 1 cycle after load_strobe is sampled in IDLE.
REQ-023 With serial_ready held high, a frame SHALL take exactly NUM_SAMPLES cycles in SHIFT.
REQ-024 load_strobe in SHIFT or DONE SHALL be ignored, leaving the frame and index unchanged, and SHALL pulse load_err on the next cycle.
REQ-025 load_strobe in IDLE while frame_done is still pulsing SHALL be accepted normally.
REQ-026 The index width SHALL be $clog2(NUM_SAMPLES).
REQ-027 Samples SHALL be passed unmodified, with no sign or width change.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, index=0, serial_out=0, serial_valid=0, serial_last=0, busy=0, frame_done=0 and load_err=0.
REQ-029 The frame register SHALL clear to 0 on reset.
REQ-030 Reset SHALL take priority over load_strobe and over transfers.
REQ-031 Reset mid-frame SHALL abort the frame without asserting frame_done.

Structure
REQ-032 NUM_SAMPLES, SAMPLE_W and the FSM state enum typedef SHALL reside in the shared fft_pkg package.
REQ-033 The sample index SHALL be implemented by one sub-module, flex_counter, with clear, count_enable, rollover_val and a rollover_flag used for serial_last.

Verification
REQ-034 Reset, then load data_par_out[i]=16'h0100+i with serial_ready=1: the bench SHALL check 48 consecutive samples 16'h0100..16'h012F, serial_last only on 16'h012F, and frame_done exactly 1 cycle after that sample.
REQ-035 Stall at index 5 by dropping serial_ready for 4 cycles: the bench SHALL check serial_out holds 16'h0105 with serial_valid=1, then resumes in order with no duplicate or skipped sample.
REQ-036 Load a second frame at index 10: the bench SHALL check load_err pulses once and the first frame's output continues unchanged.
REQ-037 Assert rst at index 20: the bench SHALL check all outputs are 0 the next cycle and that frame_done never pulses; a subsequent load SHALL restart at element 0.
REQ-038 Back-to-back frames: a load in the cycle after frame_done SHALL be accepted, with the first sample valid 1 cycle later.
REQ-039 Random serial_ready over 10 random frames: a scoreboard SHALL confirm in-order, lossless output and exactly 10 frame_done pulses.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT-path definitions: frame geometry and unloader FSM states.
// Provides NUM_SAMPLES, SAMPLE_W and the state_t enum.
package fft_pkg;

    localparam int NUM_SAMPLES = 48;
    localparam int SAMPLE_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/flex_counter.sv
// Up counter with clear, enable and a registered rollover flag.
// Ports: clk, rst, clear, count_enable, rollover_val, count_out, rollover_flag.
module flex_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         count_enable,
    input  logic [W-1:0] rollover_val,
    output logic [W-1:0] count_out,
    output logic         rollover_flag
);

    logic [W-1:0] next_count;

    // Saturates at rollover_val; the owner clears it to start again.
    always_comb begin
        next_count = count_out;
        if (clear) begin
            next_count = '0;
        end else if (count_enable && (count_out != rollover_val)) begin
            next_count = count_out + W'(1);
        end
    end

    // Flag tracks the registered count, so it is high exactly
    // while count_out equals rollover_val.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count_out     <= next_count;
            rollover_flag <= (next_count == rollover_val);
        end
    end

endmodule

// File: rtl/pts_unloader.sv
// Parallel-to-serial unloader: captures an FFT frame, streams it out
// sample by sample over valid/ready. Ports: clk, rst, load_strobe,
// data_par_out, serial_ready -> serial_out/valid/last, busy,
// frame_done, load_err.
module pts_unloader #(
    parameter int NUM_SAMPLES = fft_pkg::NUM_SAMPLES,
    parameter int SAMPLE_W    = fft_pkg::SAMPLE_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load_strobe,
    input  logic [NUM_SAMPLES-1:0][SAMPLE_W-1:0] data_par_out,
    input  logic                                serial_ready,
    output logic [SAMPLE_W-1:0]                 serial_out,
    output logic                                serial_valid,
    output logic                                serial_last,
    output logic                                busy,
    output logic                                frame_done,
    output logic                                load_err
);

    import fft_pkg::*;

    localparam int IDX_W =
        (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX =
        IDX_W'(NUM_SAMPLES - 1);

    state_t                               state;
    logic [NUM_SAMPLES-1:0][SAMPLE_W-1:0] frame;
    logic [IDX_W-1:0]                     index;
    logic [IDX_W-1:0]                     idx_nxt;
    logic                                 at_last;
    logic                                 accept;
    logic                                 xfer;

    assign accept  = (state == IDLE) && load_strobe;
    assign xfer    = serial_valid && serial_ready;
    assign idx_nxt = index + IDX_W'(1);

    // Both terms are flops, so serial_last stays glitch-free.
    assign serial_last = serial_valid && at_last;

    flex_counter #(
        .W (IDX_W)
    ) u_idx (
        .clk           (clk),
        .rst           (rst),
        .clear         (accept),
        .count_enable  (xfer),
        .rollover_val  (LAST_IDX),
        .count_out     (index),
        .rollover_flag (at_last)
    );

    // serial_out is preloaded with the next sample on each
    // transfer so the output port is driven straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            frame        <= '0;
            serial_out   <= '0;
            serial_valid <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            load_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_strobe) begin
                        frame        <= data_par_out;
                        serial_out   <= data_par_out[0];
                        serial_valid <= 1'b1;
                        busy         <= 1'b1;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    load_err <= load_strobe;
                    if (serial_ready) begin
                        if (at_last) begin
                            serial_out   <= '0;
                            serial_valid <= 1'b0;
                            busy         <= 1'b0;
                            frame_done   <= 1'b1;
                            state        <= DONE;
                        end else begin
                            serial_out <= frame[idx_nxt];
                        end
                    end
                end
                DONE: begin
                    load_err <= load_strobe;
                    state    <= IDLE;
                end
                default: begin
                    serial_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pts_unloader.sv
// Directed and randomized checks for pts_unloader.
// Table vectors plus hand sequences for stall, reject, reset, random.
`timescale 1ns/10ps
module tb_pts_unloader;

    localparam int N = 48;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                load_strobe = 1'b0;
    logic [N-1:0][W-1:0] data_par_out = '0;
    logic                serial_ready = 1'b0;
    logic [W-1:0]        serial_out;
    logic                serial_valid;
    logic                serial_last;
    logic                busy;
    logic                frame_done;
    logic                load_err;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    always #1.25 clk = ~clk;

    pts_unloader dut (
        .clk          (clk),
        .rst          (rst),
        .load_strobe  (load_strobe),
        .data_par_out (data_par_out),
        .serial_ready (serial_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .serial_last  (serial_last),
        .busy         (busy),
        .frame_done   (frame_done),
        .load_err     (load_err)
    );

    typedef struct {
        logic         rst;
        logic         load;
        logic         ready;
        logic [W-1:0] out;
        logic         valid;
        logic         last;
        logic         busy;
        logic         done;
        logic         err;
    } vec_t;

    vec_t vt[10];

    task automatic step();
        @(posedge clk);
        #1;
        if (frame_done) done_seen++;
    endtask

    task automatic chk16(input string name,
                         input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name,
                        input logic act,
                        input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic fill(input logic [W-1:0] base);
        for (int i = 0; i < N; i++)
            data_par_out[i] = base + W'(i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_strobe = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic do_load();
        load_strobe = 1'b1;
        step();
        load_strobe = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk16({tag, ".out"}, serial_out, 16'h0000);
        chk1({tag, ".valid"}, serial_valid, 1'b0);
        chk1({tag, ".last"}, serial_last, 1'b0);
        chk1({tag, ".busy"}, busy, 1'b0);
        chk1({tag, ".done"}, frame_done, 1'b0);
        chk1({tag, ".err"}, load_err, 1'b0);
    endtask

    // Streams samples start..N-1 with ready high, then checks DONE.
    task automatic run_frame(input string tag,
                             input logic [W-1:0] base,
                             input int start);
        serial_ready = 1'b1;
        for (int i = start; i < N; i++) begin
            chk16($sformatf("%s.out%0d", tag, i),
                  serial_out, base + W'(i));
            chk1($sformatf("%s.valid%0d", tag, i),
                 serial_valid, 1'b1);
            chk1($sformatf("%s.last%0d", tag, i),
                 serial_last, (i == N - 1));
            step();
        end
        chk1({tag, ".done"}, frame_done, 1'b1);
        chk1({tag, ".dvalid"}, serial_valid, 1'b0);
        chk1({tag, ".dbusy"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int d0;
        int cyc;
        logic [W-1:0] q[$];
        logic [W-1:0] e;

        // rst load rdy  out      v     l     b     d     e
        vt[0] = '{1'b1, 1'b1, 1'b1, 16'h0000,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 16'h0000,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b1, 16'h0100,
                  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b0, 16'h0100,
                  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b0, 1'b1, 16'h0101,
                  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b1, 1'b1, 16'h0102,
                  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[6] = '{1'b0, 1'b0, 1'b0, 16'h0102,
                  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[7] = '{1'b0, 1'b0, 1'b1, 16'h0103,
                  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[8] = '{1'b1, 1'b0, 1'b1, 16'h0000,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9] = '{1'b0, 1'b0, 1'b1, 16'h0000,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        fill(16'h0100);
        for (int k = 0; k < 10; k++) begin
            rst          = vt[k].rst;
            load_strobe  = vt[k].load;
            serial_ready = vt[k].ready;
            step();
            chk16($sformatf("vec%0d.out", k), serial_out, vt[k].out);
            chk1($sformatf("vec%0d.valid", k), serial_valid, vt[k].valid);
            chk1($sformatf("vec%0d.last", k), serial_last, vt[k].last);
            chk1($sformatf("vec%0d.busy", k), busy, vt[k].busy);
            chk1($sformatf("vec%0d.done", k), frame_done, vt[k].done);
            chk1($sformatf("vec%0d.err", k), load_err, vt[k].err);
        end
        load_strobe = 1'b0;

        // Full frame with ready held high.
        do_reset();
        chk_zero("rst");
        fill(16'h0100);
        serial_ready = 1'b1;
        do_load();
        run_frame("full", 16'h0100, 0);
        step();
        chk1("full.pulse1", frame_done, 1'b0);

        // Stall at index 5 for 4 cycles.
        do_load();
        for (int i = 0; i < 5; i++) step();
        serial_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            chk16($sformatf("stall.out%0d", s), serial_out, 16'h0105);
            chk1($sformatf("stall.valid%0d", s), serial_valid, 1'b1);
            step();
        end
        run_frame("stall", 16'h0100, 5);
        step();

        // Rejected load at index 10 keeps streaming frame one.
        do_load();
        for (int i = 0; i < 10; i++) step();
        chk16("rej.pre", serial_out, 16'h010A);
        fill(16'h0200);
        do_load();
        chk1("rej.err", load_err, 1'b1);
        chk16("rej.out11", serial_out, 16'h010B);
        step();
        chk1("rej.err_clr", load_err, 1'b0);
        run_frame("rej", 16'h0100, 12);

        // Load during DONE is rejected; next cycle is accepted.
        fill(16'h0400);
        do_load();
        chk1("done.err", load_err, 1'b1);
        chk1("done.valid", serial_valid, 1'b0);
        do_load();
        chk1("b2b.valid", serial_valid, 1'b1);
        chk1("b2b.busy", busy, 1'b1);
        run_frame("b2b", 16'h0400, 0);
        step();

        // Reset at index 20 aborts without frame_done.
        fill(16'h0100);
        do_load();
        for (int i = 0; i < 20; i++) step();
        chk16("abort.pre", serial_out, 16'h0114);
        d0 = done_seen;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero("abort");
        for (int i = 0; i < 6; i++) step();
        chk1("abort.nodone", done_seen == d0, 1'b1);
        fill(16'h0300);
        do_load();
        run_frame("restart", 16'h0300, 0);
        step();

        // Random ready over 10 random frames, scoreboard check.
        do_reset();
        d0 = done_seen;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < N; i++) begin
                data_par_out[i] = W'($urandom);
                q.push_back(data_par_out[i]);
            end
            serial_ready = 1'($urandom_range(0, 1));
            do_load();
            cyc = 0;
            while (done_seen == d0 + f && cyc < 600) begin
                serial_ready = 1'($urandom_range(0, 1));
                if (serial_valid && serial_ready) begin
                    if (q.size() == 0) begin
                        fail_now("rnd.extra");
                    end else begin
                        e = q.pop_front();
                        chk16($sformatf("rnd%0d.out", f), serial_out, e);
                        chk1($sformatf("rnd%0d.last", f),
                             serial_last, q.size() == 0);
                    end
                end
                step();
                cyc++;
            end
            if (cyc >= 600) fail_now($sformatf("rnd%0d.timeout", f));
            step();
        end
        chk16("rnd.done_cnt", 16'(done_seen - d0), 16'd10);
        chk16("rnd.left", 16'(q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
